// File: rtl/result_uart_tx_pkg.sv
// Shared types and line-level constants for the result UART transmitter.
package result_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam int   DATA_BITS   = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: emits a one-cycle tick on the last clock of every serial bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_tick
);

    localparam logic [7:0] TERMINAL = 8'(CLKS_PER_BIT - 1);

    logic [7:0] baud_cnt;

    // Held at zero while idle so the start bit always gets a full period.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            baud_cnt <= '0;
        end else if (baud_cnt == TERMINAL) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 8'd1;
        end
    end

    assign bit_tick = !clear && (baud_cnt == TERMINAL);

endmodule

// File: rtl/result_uart_tx.sv
// Snapshots the selected result byte and shifts it out as an 8-bit UART frame
// (optional even parity) on explicit request or when the byte changes.
module result_uart_tx
    import result_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    input  logic                 auto_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 255) begin : g_bad_clks_per_bit
        $error("result_uart_tx: CLKS_PER_BIT must be within 1..255");
    end
    if (PARITY_EN < 0 || PARITY_EN > 1) begin : g_bad_parity_en
        $error("result_uart_tx: PARITY_EN must be 0 or 1");
    end

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e            state, state_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic [DATA_BITS-1:0] last_sent, last_sent_n;
    logic                 tx_n, busy_n, done_n;
    logic                 req, bit_tick, baud_clear;

    assign req        = send | (auto_en & (data_in != last_sent));
    assign baud_clear = (state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            last_sent <= '0;
            tx        <= STOP_LEVEL;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            last_sent <= last_sent_n;
            tx        <= tx_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state logic computes the registered line value for the coming cycle.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_reg;
        last_sent_n = last_sent;
        tx_n        = tx;
        busy_n      = busy;
        done_n      = 1'b0;
        unique case (state)
            IDLE: begin
                tx_n   = STOP_LEVEL;
                busy_n = 1'b0;
                if (req) begin
                    shift_n     = data_in;
                    last_sent_n = data_in;
                    state_n     = START;
                    tx_n        = START_LEVEL;
                    busy_n      = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    tx_n      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        // last_sent still holds the snapshot, so parity comes from it.
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = ^last_sent;
                        end else begin
                            state_n = STOP;
                            tx_n    = STOP_LEVEL;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shift_n   = shift_reg >> 1;
                        tx_n      = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_n = STOP;
                    tx_n    = STOP_LEVEL;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_n = IDLE;
                    tx_n    = STOP_LEVEL;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = STOP_LEVEL;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench: three transmitter configurations share one stimulus set and
// each cycle's {tx,busy,done} is compared with a frame-level waveform model.
module tb_result_uart_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       send;
    logic       auto_en;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];

    always #5 clk = ~clk;

    result_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .send(send),
        .auto_en(auto_en), .tx(tx0), .busy(busy0), .done(done0));
    result_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .send(send),
        .auto_en(auto_en), .tx(tx1), .busy(busy1), .done(done1));
    result_uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .send(send),
        .auto_en(auto_en), .tx(tx2), .busy(busy2), .done(done2));

    // Reference waveform: a frame is the bit list start,d0..d7,[parity],stop, each
    // bit held cpb cycles with busy high; entries are {tx,busy,done}.
    function automatic void add_frame(input logic [7:0] d, input bit par_en, input int cpb);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (par_en) bits.push_back(^d);
        bits.push_back(1'b1);
        foreach (bits[k])
            for (int c = 0; c < cpb; c++) exp_q.push_back({bits[k], 1'b1, 1'b0});
    endfunction

    function automatic void add_idle(input int n, input bit first_done);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b0, (i == 0) && first_done});
    endfunction

    function automatic logic [2:0] sample(input int sel);
        case (sel)
            0:       return {tx0, busy0, done0};
            1:       return {tx1, busy1, done1};
            default: return {tx2, busy2, done2};
        endcase
    endfunction

    task automatic capture(input int sel, input int n);
        obs_q.delete();
        repeat (n) begin
            @(negedge clk);
            obs_q.push_back(sample(sel));
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; send = 1'b0; auto_en = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic pulse_send(input logic [7:0] d);
        data_in = d; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
    endtask

    task automatic test_reset();
        data_in = 8'h5A;
        apply_reset();
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (sample(s) !== 3'b100) begin
                n_fail++;
                $display("FAIL reset dut%0d {tx,busy,done}: got %b expected 100", s, sample(s));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        exp_q.delete();
        add_frame(8'hA5, 0, 4); add_idle(4, 1);
        pulse_send(8'hA5);
        capture(0, exp_q.size());
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL frame_a5 cycle %0d {tx,busy,done}: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_parity();
        logic [7:0] bytes[2] = '{8'h07, 8'h03};
        bit         pbit[2]  = '{1'b1, 1'b0};
        apply_reset();
        for (int t = 0; t < 2; t++) begin
            exp_q.delete();
            add_frame(bytes[t], 1, 4); add_idle(4, 1);
            pulse_send(bytes[t]);
            capture(1, exp_q.size());
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL parity_%h cycle %0d {tx,busy,done}: got %b expected %b", bytes[t], i, obs_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (obs_q[36][2] !== pbit[t]) begin
                n_fail++;
                $display("FAIL parity_bit_%h: got %b expected %b", bytes[t], obs_q[36][2], pbit[t]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_auto_coalesce();
        data_in = 8'h00;
        apply_reset();
        auto_en = 1'b1;
        exp_q.delete();
        add_idle(12, 0);
        capture(0, exp_q.size());
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL auto_nochange cycle %0d {tx,busy,done}: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
        data_in = 8'h3C;
        @(posedge clk); #1;
        exp_q.delete();
        add_frame(8'h3C, 0, 4); add_idle(1, 1);
        add_frame(8'h3E, 0, 4); add_idle(8, 1);
        fork
            capture(0, exp_q.size());
            begin
                repeat (10) @(posedge clk);
                #1 data_in = 8'h3D;
                repeat (10) @(posedge clk);
                #1 data_in = 8'h3E;
            end
        join
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL auto_coalesce cycle %0d {tx,busy,done}: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        data_in = 8'h11; send = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        add_frame(8'h11, 0, 4); add_idle(1, 1);
        add_frame(8'h22, 0, 4); add_idle(5, 1);
        fork
            capture(0, exp_q.size());
            begin
                repeat (20) @(posedge clk);
                #1 data_in = 8'h22;
                repeat (30) @(posedge clk);
                #1 send = 1'b0;
            end
        join
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d {tx,busy,done}: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        data_in = 8'hFF; auto_en = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        add_frame(8'hFF, 0, 4);
        while (exp_q.size() > 17) void'(exp_q.pop_back());
        add_idle(1, 0);
        add_frame(8'hFF, 0, 4); add_idle(6, 1);
        fork
            capture(0, exp_q.size());
            begin
                repeat (16) @(posedge clk);
                #1 reset_n = 1'b0;
                @(posedge clk);
                #1 reset_n = 1'b1;
            end
        join
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL reset_mid_frame cycle %0d {tx,busy,done}: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        auto_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fast_baud();
        apply_reset();
        exp_q.delete();
        add_frame(8'h80, 0, 1); add_idle(5, 1);
        pulse_send(8'h80);
        capture(2, exp_q.size());
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fast_baud cycle %0d {tx,busy,done}: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_frames();
        apply_reset();
        for (int t = 0; t < 8; t++) begin
            logic [7:0] d;
            int         sel;
            d   = 8'($urandom);
            sel = int'($urandom_range(0, 1));
            exp_q.delete();
            add_frame(d, sel == 1, 4);
            add_idle(47 - exp_q.size(), 1);
            pulse_send(d);
            capture(sel, exp_q.size());
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random_%h_dut%0d cycle %0d {tx,busy,done}: got %b expected %b", d, sel, i, obs_q[i], exp_q[i]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; data_in = 8'h00; send = 1'b0; auto_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_frame();
        test_parity();
        test_auto_coalesce();
        test_back_to_back();
        test_reset_mid_frame();
        test_fast_baud();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Downstream stage of the benchmark output mux.
- Takes the 8-bit selected result byte, snapshots it, and serialises it as a UART-style frame on a single pin, so a tester can log results with one wire.
- Transmission starts on an explicit request, or automatically whenever the byte changes.
- Fixed-ratio bit timing, derived from the design clock.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255; elaboration error outside that range.
- PARITY_EN, 0, 1 inserts an even-parity bit between data and stop.

Ports:
- clk  input  1  design clock; all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- data_in  input  8  result byte from the output mux
- send  input  1  level request to transmit data_in; sampled only in IDLE
- auto_en  input  1  when 1, a change of data_in versus last transmitted byte requests a frame
- tx  output  1  serial line; idle high
- busy  output  1  high from first start-bit cycle through last stop-bit cycle
- done  output  1  one-cycle pulse after each completed frame

Behaviour:
- Reset, sampled on a rising edge with reset_n=0:
  - state=IDLE, tx=1, busy=0, done=0.
  - Bit counter=0, baud counter=0, shift register=0x00, last_sent=0x00.
  - Reset overrides everything, including mid-frame: tx is 1 from the next cycle, and the partial frame is abandoned with no done pulse.
- Request in IDLE:
  - req = send | (auto_en & (data_in != last_sent)).
  - At the edge where req=1: data_in is loaded into the shift register and into last_sent, and state goes to START.
  - Simultaneous send and auto trigger produce exactly one frame.
- Frame order:
  - START: tx=0.
  - DATA: 8 bits, LSB first.
  - PARITY, only if PARITY_EN: XOR of the 8 data bits.
  - STOP: tx=1.
- Bit timing:
  - Each bit holds tx for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and advances the bit on its terminal count.
- Frame length: (10 + PARITY_EN) * CLKS_PER_BIT cycles with busy=1.
  - Latency from the request edge to the first start-bit cycle is 1 cycle.
- End of frame:
  - The edge ending the last stop cycle returns state to IDLE, with busy=0 and done=1 for that one IDLE cycle.
  - Requests are sampled again at the end of that cycle, giving a minimum gap of 1 idle-high cycle between frames.
- send held high continuously: back-to-back frames with the 1-cycle gap; each frame re-snapshots data_in.
- Changes of data_in while busy do not affect the frame in flight.
  - In auto mode, the comparison against last_sent after the frame coalesces intermediate changes: only the byte present in the done cycle is sent next.
- auto_en deasserted mid-frame: the current frame completes; no follow-up auto frame.
- Outputs tx, busy and done are registered; no combinational path from inputs to outputs.
- State machine: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_EN=0; no other states are reachable.

Decomposition:
- Shared package result_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants START_LEVEL=0, STOP_LEVEL=1, DATA_BITS=8.
- One sub-module, uart_baud_gen:
  - owns the CLKS_PER_BIT counter;
  - has clk, reset_n and a clear input;
  - outputs a one-cycle bit_tick on terminal count;
  - clear is held in IDLE so every frame starts phase-aligned.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0, data_in=0xA5, send pulsed 1 cycle
   -> tx=0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles; busy=1 for 40 cycles; done=1 for the single cycle after; tx=1 thereafter.
2. PARITY_EN=1, data_in=0x07, send
   -> parity bit=1; busy for 44 cycles. Repeat with 0x03 -> parity bit=0.
3. auto_en=1, data_in=0x00 after reset -> no frame. data_in=0x3C -> one frame of 0x3C. During it, data_in goes 0x3D then 0x3E -> exactly one further frame, of 0x3E, starting 1 cycle after done.
4. send held high with data_in=0x11, then 0x22 mid-first-frame
   -> frames 0x11 then 0x22; tx high for exactly 1 cycle between the stop and start bits.
5. reset_n=0 for 1 cycle during data bit 3 of a 0xFF frame
   -> next cycle tx=1, busy=0, done never pulses. With auto_en=1 and data_in=0xFF, a new full frame starts after reset releases (last_sent cleared to 0x00).
6. CLKS_PER_BIT=1, data_in=0x80, send
   -> 10-cycle frame; tx low for 8 cycles (start bit plus bits 0-6), then high for 2 cycles (bit 7 and stop).
